vga_timing_gen: RTL

//  Generates 640x480@60Hz VGA timing: pixel enable, hCount/vCount raster position, bright (active-area) and hSync/vSync.

---
 rtl/vga_timing_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster timing, blanking and registered pin stage.
// Optional bar test pattern: define VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_ACT_BEG = 144,
  parameter int unsigned H_ACT_END = 784,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_ACT_BEG = 35,
  parameter int unsigned V_ACT_END = 515
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [11:0] rgb_in,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SY   = 10'(H_SYNC);
  localparam logic [9:0] V_SY   = 10'(V_SYNC);
  localparam logic [9:0] H_BEG  = 10'(H_ACT_BEG);
  localparam logic [9:0] H_END  = 10'(H_ACT_END);
  localparam logic [9:0] V_BEG  = 10'(V_ACT_BEG);
  localparam logic [9:0] V_END  = 10'(V_ACT_END);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          tick_q, tick_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [11:0]   rgb_q, rgb_d;
  logic [11:0]   colour_src;
  logic          h_wrap;
  logic          f_wrap;

  // pixel enable is a pure decode of the registered divider
  assign pix_en = (div_q == DIV_LAST);

  // visible window, same cycle as the counters
  assign bright = (h_q >= H_BEG) && (h_q < H_END) &&
                  (v_q >= V_BEG) && (v_q < V_END);

  assign h_wrap = (h_q == H_LAST);
  assign f_wrap = pix_en && h_wrap && (v_q == V_LAST);

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0]  h_off;
  logic [2:0]  bar_idx;
  logic [11:0] pat_rgb;

  // eight 80-pixel colour bars across the visible width
  always_comb begin
    h_off   = h_q - H_BEG;
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_off >= 10'(i * 80)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
    pat_rgb = 12'h000;
    unique case (bar_idx)
      3'd0:    pat_rgb = 12'hFFF;
      3'd1:    pat_rgb = 12'hFF0;
      3'd2:    pat_rgb = 12'h0FF;
      3'd3:    pat_rgb = 12'h0F0;
      3'd4:    pat_rgb = 12'hF0F;
      3'd5:    pat_rgb = 12'hF00;
      3'd6:    pat_rgb = 12'h00F;
      3'd7:    pat_rgb = 12'h000;
      default: pat_rgb = 12'h000;
    endcase
    colour_src = test_mode ? pat_rgb : rgb_in;
  end
`else
  assign colour_src = rgb_in;
`endif

  // next-state for divider, raster counters and frame pulse
  always_comb begin
    div_d  = pix_en ? '0 : div_q + DW'(1);
    h_d    = h_q;
    v_d    = v_q;
    tick_d = f_wrap;
    if (pix_en) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // next-state for the pin stage, one pixel behind the counters
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    if (pix_en) begin
      hs_d  = !(h_q < H_SY);
      vs_d  = !(v_q < V_SY);
      rgb_d = bright ? colour_src : 12'h000;
    end
  end

  // timing state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      tick_q <= tick_d;
    end
  end

  // registered sync and colour pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign frame_tick = tick_q;
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];

endmodule
